sobel_result_packer: RTL

- Downstream stage of the Sobel edge-detection core.
- Consumes the core's per-pixel output stream (Gradient qualified by Dop, end of frame by Finish).
- Packs four consecutive 8-bit gradient pixels into one 32-bit word and writes the words to a result frame memory through a valid/ready write port.
- Holds a 2-word queue to absorb memory back-pressure, because the Sobel core cannot be stalled.

---
 rtl/sobel_pkg.sv | 20 ++
 rtl/sobel_result_packer_word_fifo.sv | 64 ++++++
 rtl/sobel_result_packer.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/sobel_pkg.sv
// Shared types and constants for the Sobel result packer.
// Holds the packer state encoding, the lane geometry and the pixel-count width helper.
package sobel_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_COLLECT,
        ST_FLUSH,
        ST_DONE
    } packer_state_e;

    localparam int LANES  = 4;
    localparam int LANE_W = 8;

    // Wide enough to hold the full frame pixel total itself.
    function automatic int pix_cnt_width(input int width, input int height);
        return $clog2(width * height + 1);
    endfunction

endpackage

// File: rtl/sobel_result_packer_word_fifo.sv
// Two-entry synchronous word queue between the packer and the result memory.
// Synchronous active-low reset; clr_i empties the queue for a frame restart.
module packer_word_fifo #(
    parameter int DATA_W = 32
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              clr_i,
    input  logic              push_i,
    input  logic              pop_i,
    input  logic [DATA_W-1:0] din_i,
    output logic [DATA_W-1:0] dout_o,
    output logic              empty_o,
    output logic              full_o
);

    logic [DATA_W-1:0] mem_q [2];
    logic              wr_ptr_q, wr_ptr_d;
    logic              rd_ptr_q, rd_ptr_d;
    logic [1:0]        cnt_q, cnt_d;
    logic              pop_ok;
    logic              push_ok;

    assign empty_o = (cnt_q == 2'd0);
    assign full_o  = (cnt_q == 2'd2);
    assign pop_ok  = pop_i && !empty_o;
    // A push onto a full queue is legal only when the head leaves in the same cycle.
    assign push_ok = push_i && (!full_o || pop_ok);
    assign dout_o  = mem_q[rd_ptr_q];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (clr_i) begin
            wr_ptr_d = 1'b0;
            rd_ptr_d = 1'b0;
            cnt_d    = 2'd0;
        end else begin
            wr_ptr_d = wr_ptr_q ^ push_ok;
            rd_ptr_d = rd_ptr_q ^ pop_ok;
            cnt_d    = cnt_q + 2'(push_ok) - 2'(pop_ok);
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            cnt_q    <= 2'd0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_ok && !clr_i) begin
            mem_q[wr_ptr_q] <= din_i;
        end
    end

endmodule

// File: rtl/sobel_result_packer.sv
// Packs four 8-bit Sobel gradient pixels per 32-bit word and streams them to the result memory.
// Optional edge statistics counter enabled by defining SOBEL_PACKER_STATS_EN.
module sobel_result_packer
    import sobel_pkg::*;
#(
    parameter int IMG_WIDTH  = 254,
    parameter int IMG_HEIGHT = 254,
    parameter int ADDR_W     = 16
) (
    input  logic              CLK,
    input  logic              Reset_n,
    input  logic              Start,
    input  logic              Dop,
    input  logic [7:0]        Gradient,
    input  logic              Finish,
    output logic              MemWe,
    output logic [ADDR_W-1:0] MemAddr,
    output logic [31:0]       MemData,
    input  logic              MemReady,
    output logic              Done,
    output logic              Overflow,
    output logic [ADDR_W+1:0] EdgeCount
);

    localparam int                 PCW       = pix_cnt_width(IMG_WIDTH, IMG_HEIGHT);
    localparam int                 IDX_W     = $clog2(LANES);
    localparam int                 WORD_W    = LANES * LANE_W;
    localparam logic [PCW-1:0]     PIX_TOTAL = PCW'(IMG_WIDTH * IMG_HEIGHT);
    localparam logic [IDX_W-1:0]   LAST_LANE = IDX_W'(LANES - 1);

    packer_state_e     state_q, state_d;
    logic [IDX_W-1:0]  byte_idx_q, byte_idx_d;
    logic [WORD_W-1:0] asm_q, asm_d;
    logic [PCW-1:0]    pix_cnt_q, pix_cnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              ovf_q, ovf_d;

    logic              accept;
    logic              pop;
    logic              push;
    logic              push_req;
    logic              go_flush;
    logic              drain_done;
    logic [WORD_W-1:0] word_fill;
    logic [WORD_W-1:0] fifo_dout;
    logic              fifo_empty;
    logic              fifo_full;

    assign accept     = (state_q == ST_COLLECT) && !Start && Dop && (pix_cnt_q != PIX_TOTAL);
    assign pop        = !fifo_empty && MemReady;
    // Queue will be empty after this edge (no pushes happen once the frame has ended).
    assign drain_done = fifo_empty || (!fifo_full && pop);

    // Lanes at or above byte_idx are always zero in asm_q, so a partial word is already padded.
    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
        assign word_fill[gi*LANE_W +: LANE_W] =
            (accept && (byte_idx_q == IDX_W'(gi))) ? Gradient : asm_q[gi*LANE_W +: LANE_W];
    end

    always_comb begin
        state_d    = state_q;
        byte_idx_d = byte_idx_q;
        asm_d      = asm_q;
        pix_cnt_d  = pix_cnt_q;
        addr_d     = addr_q + ADDR_W'(pop);
        ovf_d      = ovf_q;
        push_req   = 1'b0;
        push       = 1'b0;
        go_flush   = 1'b0;
        if (Start) begin
            state_d    = ST_COLLECT;
            byte_idx_d = '0;
            asm_d      = '0;
            pix_cnt_d  = '0;
            addr_d     = '0;
            ovf_d      = 1'b0;
        end else begin
            unique case (state_q)
                ST_COLLECT: begin
                    pix_cnt_d  = pix_cnt_q + PCW'(accept);
                    byte_idx_d = byte_idx_q + IDX_W'(accept);
                    asm_d      = word_fill;
                    go_flush   = Finish || (pix_cnt_d == PIX_TOTAL);
                    push_req   = (accept && (byte_idx_q == LAST_LANE))
                              || (go_flush && (byte_idx_d != '0));
                    push       = push_req && (!fifo_full || pop);
                    if (push_req && !push) begin
                        ovf_d = 1'b1;
                    end
                    if (push_req || go_flush) begin
                        asm_d = '0;
                    end
                    if (go_flush) begin
                        byte_idx_d = '0;
                        state_d    = (!push_req && drain_done) ? ST_DONE : ST_FLUSH;
                    end
                end
                ST_FLUSH: begin
                    if (drain_done) begin
                        state_d = ST_DONE;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (!Reset_n) begin
            state_q    <= ST_IDLE;
            byte_idx_q <= '0;
            asm_q      <= '0;
            pix_cnt_q  <= '0;
            addr_q     <= '0;
            ovf_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            byte_idx_q <= byte_idx_d;
            asm_q      <= asm_d;
            pix_cnt_q  <= pix_cnt_d;
            addr_q     <= addr_d;
            ovf_q      <= ovf_d;
        end
    end

    packer_word_fifo #(
        .DATA_W (WORD_W)
    ) u_fifo (
        .clk_i   (CLK),
        .rst_n_i (Reset_n),
        .clr_i   (Start),
        .push_i  (push),
        .pop_i   (pop),
        .din_i   (word_fill),
        .dout_o  (fifo_dout),
        .empty_o (fifo_empty),
        .full_o  (fifo_full)
    );

`ifdef SOBEL_PACKER_STATS_EN
    logic [ADDR_W+1:0] edge_q, edge_d;

    always_comb begin
        edge_d = edge_q;
        if (Start) begin
            edge_d = '0;
        end else if (accept && (Gradient != 8'd0)) begin
            edge_d = edge_q + (ADDR_W+2)'(1);
        end
    end

    always_ff @(posedge CLK) begin
        if (!Reset_n) begin
            edge_q <= '0;
        end else begin
            edge_q <= edge_d;
        end
    end

    assign EdgeCount = edge_q;
`else
    assign EdgeCount = '0;
`endif

    assign MemWe    = !fifo_empty;
    assign MemAddr  = addr_q;
    assign MemData  = fifo_empty ? '0 : fifo_dout;
    assign Done     = (state_q == ST_DONE);
    assign Overflow = ovf_q;

endmodule
